riscv_lsu: RTL

Parametrised load/store unit that replaces the fixed single-cycle data-memory path of the 3-stage core. It accepts one memory request per handshake from the EX stage and decodes the region (DMEM block RAM or MMIO) from the address tag. It formats store data and byte enables, then waits a configurable read latency or an MMIO ready handshake. It returns aligned, sign- or zero-extended load data to the MWB stage, and raises a stall while a request is outstanding. It adds misalignment and access-fault reporting, which the current datapath lacks.

---
 rtl/riscv_lsu_pkg.sv | 22 ++
 rtl/riscv_lsu_load_align.sv | 41 ++++
 rtl/riscv_lsu.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM state encoding and response error codes.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_FAULT    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_MMIO_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Load return formatter: selects byte/half/word from a raw 32-bit
// word by address offset and funct3, then sign- or zero-extends.
// Ports: i_word raw data, i_addr_lo addr[1:0], i_fnc3, o_data result.
module lsu_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_fnc3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_addr_lo)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = 32'h0;
        case (i_fnc3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'h0, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_data = {16'h0, w_half};
            F3_LW:   o_data = i_word;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one request at a time from EX, routed to DMEM block
// RAM or MMIO by addr[31:28], with alignment/fault checks.
// Ports: req_* from EX, resp_* to MWB, stall to pipeline,
// dmem_* to block RAM, mmio_* to the MMIO bus.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int         DMEM_ADDR_W  = 14,
    parameter int         READ_LATENCY = 1,
    parameter logic [3:0] DMEM_TAG     = 4'h1,
    parameter logic [3:0] MMIO_TAG     = 4'h8,
    parameter int         MMIO_ADDR_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_fnc3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [4:0]             req_rd,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic [4:0]             resp_rd,
    output logic [1:0]             resp_err,
    output logic                   stall,
    output logic [3:0]             dmem_we,
    output logic [DMEM_ADDR_W-1:0] dmem_addr,
    output logic [31:0]            dmem_din,
    input  logic [31:0]            dmem_dout,
    output logic                   mmio_valid,
    output logic                   mmio_we,
    output logic [MMIO_ADDR_W-1:0] mmio_addr,
    output logic [31:0]            mmio_wdata,
    input  logic [31:0]            mmio_rdata,
    input  logic                   mmio_ready
);

    lsu_state_e r_state;
    lsu_state_e w_state_nxt;

    logic [2:0]             r_cnt;
    logic [2:0]             r_fnc3;
    logic [1:0]             r_addr_lo;
    logic [DMEM_ADDR_W-1:0] r_dmem_addr;
    logic [4:0]             r_rd;
    logic [1:0]             r_err;
    logic [31:0]            r_rdata;
    logic                   r_mmio_valid;
    logic                   r_mmio_we;
    logic [MMIO_ADDR_W-1:0] r_mmio_addr;
    logic [31:0]            r_mmio_wdata;

    logic        w_accept;
    logic        w_load_ok;
    logic        w_store_ok;
    logic        w_legal;
    logic        w_misal;
    logic        w_is_dmem;
    logic        w_is_mmio;
    logic [1:0]  w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_fmt;
    logic [31:0] w_raw;
    logic [31:0] w_align;
    logic        w_unused;

    // Only part of the address reaches either memory.
    assign w_unused = ^req_addr;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_load_ok  = req_fnc3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    assign w_store_ok = req_fnc3 inside {F3_LB, F3_LH, F3_LW};
    assign w_legal    = req_we ? w_store_ok : w_load_ok;

    // Size comes from fnc3[1:0]; only judged for legal encodings.
    assign w_misal = w_legal &&
        (((req_fnc3[1:0] == 2'b01) && req_addr[0]) ||
         ((req_fnc3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));

    assign w_is_dmem = (req_addr[31:28] == DMEM_TAG);
    assign w_is_mmio = (req_addr[31:28] == MMIO_TAG);

    always_comb begin
        w_err = ERR_OK;
        if (w_misal)
            w_err = ERR_MISALIGN;
        else if (!w_legal || !(w_is_dmem || w_is_mmio))
            w_err = ERR_FAULT;
    end

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_fmt = req_wdata;
        unique case (req_fnc3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_wdata_fmt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_fmt = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_fmt = req_wdata;
            end
        endcase
    end

    // One formatter serves both return paths.
    assign w_raw = (r_state == ST_MMIO_WAIT) ? mmio_rdata : dmem_dout;

    lsu_load_align u_align (
        .i_word    (w_raw),
        .i_addr_lo (r_addr_lo),
        .i_fnc3    (r_fnc3),
        .o_data    (w_align)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        stall       = 1'b1;
        dmem_we     = 4'b0000;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (w_accept) begin
                    if (w_err != ERR_OK) begin
                        w_state_nxt = ST_RESP;
                    end else if (w_is_dmem) begin
                        if (req_we) begin
                            dmem_we     = w_be;
                            w_state_nxt = ST_RESP;
                        end else begin
                            w_state_nxt = ST_DMEM_WAIT;
                        end
                    end else begin
                        w_state_nxt = ST_MMIO_WAIT;
                    end
                end
            end
            ST_DMEM_WAIT: begin
                if (r_cnt == 3'd1)
                    w_state_nxt = ST_RESP;
            end
            ST_MMIO_WAIT: begin
                if (mmio_ready)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 3'd0;
            r_fnc3       <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_dmem_addr  <= '0;
            r_rd         <= 5'd0;
            r_err        <= ERR_OK;
            r_rdata      <= 32'h0;
            r_mmio_valid <= 1'b0;
            r_mmio_we    <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= 32'h0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fnc3      <= req_fnc3;
                        r_addr_lo   <= req_addr[1:0];
                        r_dmem_addr <= req_addr[DMEM_ADDR_W+1:2];
                        r_err       <= w_err;
                        r_rdata     <= 32'h0;
                        r_rd        <= ((w_err == ERR_OK) && !req_we)
                                       ? req_rd : 5'd0;
                        if ((w_err == ERR_OK) && w_is_dmem && !req_we)
                            r_cnt <= 3'(READ_LATENCY);
                        if ((w_err == ERR_OK) && w_is_mmio) begin
                            r_mmio_valid <= 1'b1;
                            r_mmio_we    <= req_we;
                            r_mmio_addr  <= req_addr[MMIO_ADDR_W-1:0];
                            r_mmio_wdata <= w_wdata_fmt;
                        end
                    end
                end
                ST_DMEM_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1)
                        r_rdata <= w_align;
                end
                ST_MMIO_WAIT: begin
                    if (mmio_ready) begin
                        r_mmio_valid <= 1'b0;
                        r_rdata      <= r_mmio_we ? 32'h0 : w_align;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // DMEM address stays on the request while the read is in flight.
    assign dmem_addr = (r_state == ST_IDLE)
                       ? req_addr[DMEM_ADDR_W+1:2] : r_dmem_addr;
    assign dmem_din  = w_wdata_fmt;

    assign mmio_valid = r_mmio_valid;
    assign mmio_we    = r_mmio_we;
    assign mmio_addr  = r_mmio_addr;
    assign mmio_wdata = r_mmio_wdata;

    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign resp_rd    = resp_valid ? r_rd : 5'd0;
    assign resp_err   = resp_valid ? r_err : ERR_OK;

endmodule
